// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] MEM_POISON      = 32'hDEADBEEF;
  localparam int          TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/mem_wdog.sv
// REQ-phase watchdog: reports expiry on the TIMEOUT_CYC-th enabled cycle after a clear.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_wdog
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Down-count from TIMEOUT_CYC-1 so the terminal count lands on the last allowed REQ cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer: issues req/ack memory transactions and stalls the pipeline until done.
// Optional REQ timeout watchdog enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access outstanding; a new load/store launches a request
// REQ   | request on the bus, address/data frozen, waiting for ack
// DONE  | access complete, hold released so the pipeline advances
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              hold_o,
  output logic              err_o
);

  mem_state_e state;
  logic       access;
  logic       wdog_expired;

  assign access = MemRead_i | MemWrite_i;
  assign hold_o = ((state == IDLE) && access) || (state == REQ);

`ifdef MEM_TIMEOUT_EN
  mem_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     ((state == IDLE) && access),
    .en      (state == REQ),
    .expired (wdog_expired)
  );

  // Sticky until reset; an ack in the expiry cycle takes priority.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_o <= 1'b0;
    end else if ((state == REQ) && !mem_ack_i && wdog_expired) begin
      err_o <= 1'b1;
    end
  end
`else
  // Without the watchdog a request never expires (TIMEOUT_CYC is non-negative).
  assign wdog_expired = (TIMEOUT_CYC < 0);
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state       <= REQ;
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= mem_rdata_i;
          end else if (wdog_expired) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= DATA_W'(MEM_POISON);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
